// File: rtl/top10_pkg.sv
// Shared constants, state encoding and helpers for the top-10 rank sorter.
package top10_pkg;

    localparam int TOP_K = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/top10_slot.sv
// One rank of the ordered list: holds, shifts down from the slot above, or loads the new element.
module top10_slot #(
    parameter int WIDTH = 32,
    parameter int ID_W  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_ins,
    input  logic [WIDTH-1:0] i_new_val,
    input  logic [ID_W-1:0]  i_new_id,
    input  logic             i_above_cand,
    input  logic [WIDTH-1:0] i_above_val,
    input  logic [ID_W-1:0]  i_above_id,
    input  logic             i_above_valid,
    output logic             o_cand,
    output logic [WIDTH-1:0] o_val,
    output logic [ID_W-1:0]  o_id,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_val;
    logic [ID_W-1:0]  r_id;
    logic             r_valid;

    // Strict compare keeps equal values in arrival order.
    assign o_cand  = !r_valid || (i_new_val > r_val);
    assign o_val   = r_val;
    assign o_id    = r_id;
    assign o_valid = r_valid;

    // The list stays descending with valid entries first, so candidates form a
    // contiguous run from the insertion point downward: a candidate slot whose
    // upper neighbour is also a candidate must shift rather than load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_val   <= '0;
            r_id    <= '0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_ins) begin
            if (i_above_cand) begin
                r_val   <= i_above_val;
                r_id    <= i_above_id;
                r_valid <= i_above_valid;
            end else if (o_cand) begin
                r_val   <= i_new_val;
                r_id    <= i_new_id;
                r_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/top10_sorter.sv
// Snapshots M rank values and insertion-sorts them, one per clock, into a 10-entry list.
//   state | meaning
//   IDLE  | waiting for enable; snapshot captured on the enable edge
//   SCAN  | inserting snapshot element idx into the list each clock
//   DONE  | list copied to outputs once, sorted held until reset
module top10_sorter
    import top10_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int M     = 64,
    parameter int ID_W  = clog2(M)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [M*WIDTH-1:0]       array_in,
    output logic [TOP_K*WIDTH-1:0]   top10_vals,
    output logic [TOP_K*ID_W-1:0]    top10_ids,
    output logic                     sorted
);

    state_t                   r_state, w_next;
    logic [M*WIDTH-1:0]       r_snap;
    logic [ID_W-1:0]          r_idx;
    logic [TOP_K*WIDTH-1:0]   r_vals;
    logic [TOP_K*ID_W-1:0]    r_ids;
    logic                     r_sorted;

    logic                     w_start, w_ins, w_last;
    logic [WIDTH-1:0]         w_sval   [TOP_K];
    logic [ID_W-1:0]          w_sid    [TOP_K];
    logic [TOP_K-1:0]         w_svalid;
    logic [TOP_K-1:0]         w_cand;

    assign w_start = (r_state == IDLE) && enable;
    assign w_ins   = (r_state == SCAN);
    assign w_last  = (r_idx == ID_W'(M-1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (enable) w_next = SCAN;
            SCAN:    if (w_last) w_next = DONE;
            DONE:    w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    // Snapshot shifts right each insert, so the current element is always the low word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_snap   <= '0;
            r_idx    <= '0;
            r_vals   <= '0;
            r_ids    <= '0;
            r_sorted <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_snap <= array_in;
                r_idx  <= '0;
            end else if (w_ins) begin
                r_snap <= r_snap >> WIDTH;
                r_idx  <= r_idx + 1'b1;
            end
            if ((r_state == DONE) && !r_sorted) begin
                for (int r = 0; r < TOP_K; r++) begin
                    r_vals[r*WIDTH +: WIDTH] <= w_sval[r];
                    r_ids[r*ID_W +: ID_W]    <= w_sid[r];
                end
                r_sorted <= 1'b1;
            end
        end
    end

    for (genvar s = 0; s < TOP_K; s++) begin : g_slot
        logic             w_acand;
        logic [WIDTH-1:0] w_aval;
        logic [ID_W-1:0]  w_aid;
        logic             w_avalid;

        if (s == 0) begin : g_head
            assign w_acand  = 1'b0;
            assign w_aval   = '0;
            assign w_aid    = '0;
            assign w_avalid = 1'b0;
        end else begin : g_body
            assign w_acand  = w_cand[s-1];
            assign w_aval   = w_sval[s-1];
            assign w_aid    = w_sid[s-1];
            assign w_avalid = w_svalid[s-1];
        end

        top10_slot #(.WIDTH(WIDTH), .ID_W(ID_W)) u_slot (
            .clk           (clk),
            .reset         (reset),
            .i_clear       (w_start),
            .i_ins         (w_ins),
            .i_new_val     (r_snap[WIDTH-1:0]),
            .i_new_id      (r_idx),
            .i_above_cand  (w_acand),
            .i_above_val   (w_aval),
            .i_above_id    (w_aid),
            .i_above_valid (w_avalid),
            .o_cand        (w_cand[s]),
            .o_val         (w_sval[s]),
            .o_id          (w_sid[s]),
            .o_valid       (w_svalid[s])
        );
    end

    assign top10_vals = r_vals;
    assign top10_ids  = r_ids;
    assign sorted     = r_sorted;

endmodule

// File: tb/tb_top10_sorter.sv
// Self-checking bench for top10_sorter: table of input patterns with expected top-10 lists.
module tb_top10_sorter;

    localparam int W  = 32;
    localparam int M  = 64;
    localparam int IW = 6;
    localparam int K  = 10;

    typedef struct packed {
        logic [K*W-1:0]  vals;
        logic [K*IW-1:0] ids;
    } exp_t;

    typedef struct {
        int   kind;
        exp_t exp;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic [M*W-1:0]     array_in;
    logic [K*W-1:0]     top10_vals;
    logic [K*IW-1:0]    top10_ids;
    logic               sorted;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    vec_t tbl[4];

    always #5 clk = ~clk;

    top10_sorter #(.WIDTH(W), .M(M), .ID_W(IW)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .array_in   (array_in),
        .top10_vals (top10_vals),
        .top10_ids  (top10_ids),
        .sorted     (sorted)
    );

    function automatic logic [M*W-1:0] make_arr(input int kind);
        logic [M*W-1:0] a;
        a = '0;
        for (int i = 0; i < M; i++) begin
            case (kind)
                0:       a[i*W +: W] = W'(i);
                1:       a[i*W +: W] = W'(1000 - i);
                2:       a[i*W +: W] = 32'd7;
                default: a[i*W +: W] = 32'd0;
            endcase
        end
        if (kind == 3) begin
            a[40*W +: W] = 32'hFFFF_FFFF;
            a[5*W +: W]  = 32'h8000_0000;
        end
        return a;
    endfunction

    function automatic exp_t exp_for(input int kind);
        exp_t e;
        int   nid;
        e   = '0;
        nid = 0;
        for (int r = 0; r < K; r++) begin
            case (kind)
                0: begin e.vals[r*W +: W] = W'(63 - r);   e.ids[r*IW +: IW] = IW'(63 - r); end
                1: begin e.vals[r*W +: W] = W'(1000 - r); e.ids[r*IW +: IW] = IW'(r);      end
                2: begin e.vals[r*W +: W] = 32'd7;        e.ids[r*IW +: IW] = IW'(r);      end
                default: begin
                    if (r == 0) begin
                        e.vals[r*W +: W] = 32'hFFFF_FFFF; e.ids[r*IW +: IW] = 6'd40;
                    end else if (r == 1) begin
                        e.vals[r*W +: W] = 32'h8000_0000; e.ids[r*IW +: IW] = 6'd5;
                    end else begin
                        if (nid == 5) nid++;
                        e.vals[r*W +: W] = 32'd0; e.ids[r*IW +: IW] = IW'(nid);
                        nid++;
                    end
                end
            endcase
        end
        return e;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".sorted"}, 64'(sorted), 64'd0);
        check({tag, ".vals_zero"}, 64'(|top10_vals), 64'd0);
        check({tag, ".ids_zero"}, 64'(|top10_ids), 64'd0);
    endtask

    task automatic wait_sorted(input string tag, input int start);
        int cyc;
        cyc = start;
        while (!sorted && cyc < 200) begin
            tick();
            cyc++;
        end
        check({tag, ".latency"}, 64'(cyc), 64'd65);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb_q.pop_front();
        for (int r = 0; r < K; r++) begin
            check($sformatf("%s.val%0d", tag, r), 64'(top10_vals[r*W +: W]), 64'(e.vals[r*W +: W]));
            check($sformatf("%s.id%0d", tag, r), 64'(top10_ids[r*IW +: IW]), 64'(e.ids[r*IW +: IW]));
        end
    endtask

    task automatic start_sort(input int kind);
        array_in = make_arr(kind);
        sb_q.push_back(exp_for(kind));
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            tbl[k].kind = k;
            tbl[k].exp  = exp_for(k);
        end

        reset    = 1'b1;
        enable   = 1'b0;
        array_in = '0;
        tick();
        tick();
        reset = 1'b0;
        check_zero("reset");
        array_in = make_arr(0);
        repeat (3) tick();
        check("idle_no_enable.sorted", 64'(sorted), 64'd0);

        // Table-driven patterns: ascending, descending, ties, extreme values.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            array_in = make_arr(tbl[v].kind);
            sb_q.push_back(tbl[v].exp);
            enable = 1'b1;
            tick();
            enable = 1'b0;
            wait_sorted($sformatf("vec%0d", v), 0);
            compare_out($sformatf("vec%0d", v));
        end

        // Inputs disturbed mid-SCAN must not affect the captured snapshot.
        do_reset();
        start_sort(0);
        repeat (20) tick();
        check("scan.no_partial", 64'(|top10_vals | sorted), 64'd0);
        array_in = make_arr(1);
        enable   = 1'b1;
        repeat (5) tick();
        enable   = 1'b0;
        array_in = '1;
        wait_sorted("scramble", 25);
        compare_out("scramble");

        // After DONE outputs hold regardless of inputs.
        sb_q.push_back(exp_for(0));
        array_in = make_arr(2);
        enable   = 1'b1;
        repeat (10) tick();
        enable = 1'b0;
        tick();
        check("done_hold.sorted", 64'(sorted), 64'd1);
        compare_out("done_hold");

        // Reset at idx=30 aborts, then a fresh sort completes normally.
        do_reset();
        array_in = make_arr(1);
        enable   = 1'b1;
        tick();
        enable = 1'b0;
        repeat (30) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_zero("mid_reset");
        repeat (3) tick();
        check("mid_reset.idle", 64'(sorted), 64'd0);
        start_sort(3);
        wait_sorted("after_reset", 0);
        compare_out("after_reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
